// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/adder.sv
// One-bit full adder, stepped once per clock by the serial controller.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: accepts operands, ripples them LSB-first through a
// single full adder, then holds sum and carry-out until the consumer takes them.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q,    sum_sr_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  logic               fa_sum;
  logic               fa_cout;

  adder u_adder (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state, datapath and handshake-flag logic
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a_i;
          b_sr_d  = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        // Counter saturates on the last bit so it never wraps
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum_o     = sum_sr_q;
  assign cout_o    = carry_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench: an 8-bit instance for protocol cases, a 4-bit one for the exhaustive sweep.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0] a4, b4, sum4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a_i(a8), .b_i(b8), .cin_i(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum_o(sum8), .cout_o(cout8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a_i(a4), .b_i(b4), .cin_i(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum_o(sum4), .cout_o(cout4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one op on the 8-bit DUT and return the cycles until out_valid
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat);
    a8 = a; b8 = b; cin8 = cin; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~cin;
    check("accept_busy", busy8, 1);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    start8(a, b, cin, lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_sum"}, sum8, exp_sum);
    check({tag, "_cout"}, cout8, exp_cout);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check({tag, "_idle"}, {in_ready8, out_valid8, busy8}, 3'b100);
  endtask

  initial begin
    int lat;
    int pulses;
    int prev_acc;
    int guard;
    logic [4:0] exp5;

    rst_n = 1'b0;
    in_valid8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; out_ready8 = 1'b0;
    in_valid4 = 1'b1; a4 = 4'h3;  b4 = 4'h4;  cin4 = 1'b1; out_ready4 = 1'b1;

    // Reset held with in_valid asserted
    tick();
    tick();
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_busy", busy8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst4_flags", {in_ready4, out_valid4, busy4, sum4, cout4}, 8'b1000_0000);
    in_valid8 = 1'b0;
    in_valid4 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_no_accept", {in_ready8, busy8}, 2'b10);

    op8("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    op8("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("ovf_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure in DONE with stray requests
    start8(8'h81, 8'h82, 1'b0, lat);
    check("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1;
      a8 = 8'(i * 17);
      b8 = 8'(i * 3);
      tick();
      check("bp_out_valid", out_valid8, 1);
      check("bp_sum", sum8, 8'h03);
      check("bp_cout", cout8, 1);
      check("bp_in_ready", in_ready8, 0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("bp_release", {in_ready8, out_valid8, busy8}, 3'b100);
    tick();
    check("bp_no_queue", {in_ready8, busy8}, 2'b10);

    // Reset pulse while cnt == 3
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_idle", {in_ready8, out_valid8, busy8}, 3'b100);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    op8("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Exhaustive WIDTH=4, back-to-back, out_ready tied high
    in_valid4 = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i);
      b4 = 4'(i >> 4);
      cin4 = 1'((i >> 8) & 1);
      guard = 0;
      while (!in_ready4 && guard < 20) begin
        tick();
        guard++;
      end
      tick();
      if (i > 0) check("ex_period", cyc - prev_acc, 6);
      prev_acc = cyc;
      guard = 0;
      while (!out_valid4 && guard < 20) begin
        tick();
        guard++;
      end
      exp5 = 5'(a4) + 5'(b4) + 5'(cin4);
      check("ex_out_valid", out_valid4, 1);
      check("ex_result", {cout4, sum4}, exp5);
    end
    in_valid4 = 1'b0;
    tick();
    tick();
    check("ex_end_idle", {in_ready4, busy4}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that reuses the team's 1-bit full adder (`adder`) to compute an N-bit sum. Operands come in through a valid/ready handshake. The block then steps the full adder once per clock, LSB first, and carries between bits in a register. The N-bit result and carry-out go out through a second valid/ready handshake. It is the sequencing layer that turns the single-bit adder into a multi-bit arithmetic unit, trading latency for area.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a_i`  in  WIDTH  operand A.
- `b_i`  in  WIDTH  operand B.
- `cin_i`  in  1  carry-in.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `sum_o`  out  WIDTH  result, `(a_i + b_i + cin_i) mod 2^WIDTH`.
- `cout_o`  out  1  carry-out of the MSB.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
  - `busy` = !IDLE.
- **IDLE, `in_valid`=1:**
  - load `a_i`/`b_i` into shift registers `a_sr`/`b_sr`;
  - `carry <= cin_i`, `cnt <= 0`;
  - go to RUN.
- **RUN, every cycle:**
  - full adder takes `a_sr[0]`, `b_sr[0]`, `carry`;
  - `sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}`;
  - `a_sr`/`b_sr` shift right by 1;
  - `carry <= fa_cout`, `cnt++`;
  - when `cnt == WIDTH-1`, go to DONE.
- **DONE:**
  - `sum_o` = `sum_sr`, `cout_o` = `carry`, both stable;
  - `out_ready`=1 returns to IDLE.
- Width rules:
  - `cnt` is `$clog2(WIDTH)` bits and never wraps past WIDTH-1.
  - Sum is modulo 2^WIDTH; the overflow bit appears only on `cout_o`.
- Boundary conditions:
  - `in_valid` while busy: ignored, no queueing.
  - `a_i`/`b_i`/`cin_i` changes after acceptance: no effect.
  - `out_ready` outside DONE: ignored.
  - Reset mid-operation: any state goes to IDLE at the next edge, the in-flight operation is discarded, and no `out_valid` pulse appears.
- Output values outside DONE: `sum_o`/`cout_o` track internal registers and are not meaningful. Checkers sample them only when `out_valid`=1.

## Timing
- Reset values (first edge with `rst_n`=0): state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum_o`=0, `cout_o`=0, `carry`=0, `cnt`=0.
- Input handshake at edge k puts RUN in effect for edges k+1 … k+WIDTH. `out_valid` rises after edge k+WIDTH, i.e. latency WIDTH cycles.
- Output handshake at edge m gives IDLE after m and `in_ready`=1 in cycle m+1. The earliest next accept is edge m+1.
- Maximum throughput with `out_ready` tied high: one result per WIDTH+2 cycles.
- All handshake outputs are decoded from registered state only. There are no combinational input→output paths.

## Structure
- Shared package `serial_adder_pkg` holds `typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t`.
- Counter width depends on `WIDTH`, so it is a localparam in the module, not in the package.
- One sub-module instance: `adder` (ports `a`, `b`, `cin`, `sum`, `cout`), fed by `a_sr[0]`, `b_sr[0]`, `carry`.
- The FSM, shift registers and counter stay in a single module.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1. Required: `in_ready`=1, `out_valid`=0, `busy`=0, `sum_o`=0, and no operation accepted.
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0. Required: `out_valid` exactly 8 cycles after accept, `sum_o`=0x96, `cout_o`=0.
- **Overflow, carry-out only:** a=0xFF, b=0x01, cin=0 gives sum 0x00, cout 1.
- **Overflow with carry-in:** a=0xFF, b=0xFF, cin=1 gives sum 0xFF, cout 1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE with new `in_valid`=1 pulses. Required:
  - `out_valid`/`sum_o`/`cout_o` stable, `in_ready`=0, extra requests ignored;
  - after `out_ready`=1, IDLE next cycle.
- **Mid-op reset:** `rst_n`=0 for one cycle during RUN at `cnt`=3. Required: IDLE next cycle, no `out_valid` pulse; the following op a=0x12, b=0x34 returns 0x46.
- **Exhaustive:** WIDTH=4, all 512 (a,b,cin) combinations back-to-back with `out_ready`=1. Required: every result matches a+b+cin, and the period between accepts is 6 cycles.
